// File: rtl/jogo_pkg.sv
// Shared definitions for the round controller: state encoding (also used as
// the db_estado debug code), the clog2 helper and default parameter values.
package jogo_pkg;

  localparam int CELLS_DEF   = 9;
  localparam int PLAYERS_DEF = 2;
  localparam int TIMEOUT_DEF = 5000;

  // The enum value is the debug code presented on db_estado.
  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    ESPERA_MACRO   = 4'd2,
    REGISTRA_MACRO = 4'd3,
    ESPERA_MICRO   = 4'd4,
    VALIDA_MICRO   = 4'd5,
    COMMIT         = 4'd6,
    TROCA          = 4'd7,
    FIM            = 4'd8
  } estado_t;

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/detector_botao.sv
// Button front end: two-flop synchroniser, rising-edge detector that accepts
// only events where exactly one button rises, and one-hot-to-index encoder.
//
// Output protocol: press is a one-cycle strobe; indice is valid in the same
// cycle as press and holds its value until the next press. There is no
// back-pressure: a strobe that the consumer does not act on is simply lost.
module detector_botao
  import jogo_pkg::*;
#(
  parameter int CELLS = CELLS_DEF,
  localparam int IW   = clog2(CELLS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CELLS-1:0] botoes,
  output logic             press,
  output logic [IW-1:0]    indice
);

  logic [CELLS-1:0] sync1;
  logic [CELLS-1:0] sync2;
  logic [CELLS-1:0] prev;
  logic [CELLS-1:0] rise;
  logic             one_rise;
  logic [IW-1:0]    enc;

  // Synchronise the raw buttons and keep the previous synchronised sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= botoes;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Rising bits, single-rise qualification and index encoding.
  always_comb begin
    rise     = sync2 & ~prev;
    one_rise = (rise != '0) && ((rise & (rise - CELLS'(1))) == '0);
    enc      = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (rise[i]) enc = IW'(i);
    end
  end

  // Register the strobe; the index is only updated on an accepted press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      press  <= 1'b0;
      indice <= '0;
    end else begin
      press <= one_rise;
      if (one_rise) indice <= enc;
    end
  end

endmodule

// File: rtl/controlador_rodada.sv
// Turn controller for ultimate tic-tac-toe: collects a macro-board choice and
// a micro-cell choice per turn, commits the move, rotates players and forces
// the next macro board where the rules require it.
// Optional feature: define TURN_TIMEOUT_EN to add the per-turn forfeit timer;
// without it the waits are unbounded and timeout stays 0.
module controlador_rodada
  import jogo_pkg::*;
#(
  parameter int CELLS   = CELLS_DEF,
  parameter int PLAYERS = PLAYERS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int IW     = clog2(CELLS),
  localparam int PW     = max1(clog2(PLAYERS)),
  localparam int TW     = max1(clog2(TIMEOUT))
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iniciar,
  input  logic [CELLS-1:0] botoes,
  input  logic [CELLS-1:0] macro_ocupada,
  input  logic [CELLS-1:0] micro_ocupada,
  input  logic             fim_jogo,
  output logic [IW-1:0]    macro,
  output logic [IW-1:0]    micro,
  output logic [PW-1:0]    jogador,
  output logic             jogada_valida,
  output logic             jogar_macro,
  output logic             jogar_micro,
  output logic             timeout,
  output logic             pronto,
  output logic [3:0]       db_estado
);

  estado_t       estado, estado_n;
  logic [IW-1:0] macro_n, micro_n, escolha, escolha_n;
  logic [PW-1:0] jogador_n, jogador_prox;
  logic          press;
  logic [IW-1:0] indice;
  logic          timer_clear, timer_count, timer_hit;

  detector_botao #(.CELLS(CELLS)) u_detector (
    .clock  (clock),
    .reset  (reset),
    .botoes (botoes),
    .press  (press),
    .indice (indice)
  );

`ifdef TURN_TIMEOUT_EN
  logic [TW-1:0] timer;

  // Turn timer: cleared by the FSM, counts only while waiting for a choice.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (timer_clear) begin
      timer <= '0;
    end else if (timer_count) begin
      timer <= timer + TW'(1);
    end
  end

  assign timer_hit = (timer == TW'(TIMEOUT - 1));
`else
  logic unused_timer;
  assign unused_timer = timer_clear | timer_count | (TIMEOUT < 2);
  assign timer_hit    = 1'b0;
`endif

  // Player rotation modulo PLAYERS.
  assign jogador_prox = (jogador == PW'(PLAYERS - 1)) ? '0 : jogador + PW'(1);

  // State and selection registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado  <= INICIAL;
      macro   <= '0;
      micro   <= '0;
      jogador <= '0;
      escolha <= '0;
    end else begin
      estado  <= estado_n;
      macro   <= macro_n;
      micro   <= micro_n;
      jogador <= jogador_n;
      escolha <= escolha_n;
    end
  end

  // Next-state logic, selection updates and timer control.
  always_comb begin
    estado_n    = estado;
    macro_n     = macro;
    micro_n     = micro;
    jogador_n   = jogador;
    escolha_n   = escolha;
    timer_clear = 1'b0;
    timer_count = 1'b0;
    timeout     = 1'b0;
    case (estado)
      INICIAL: begin
        if (iniciar) estado_n = PREPARA;
      end
      PREPARA: begin
        macro_n     = '0;
        micro_n     = '0;
        jogador_n   = '0;
        timer_clear = 1'b1;
        estado_n    = ESPERA_MACRO;
      end
      ESPERA_MACRO: begin
        timer_count = 1'b1;
        // A press on a closed board is not a valid choice and does not
        // rescue the player from the timer.
        if (press && !macro_ocupada[indice]) begin
          escolha_n   = indice;
          timer_clear = 1'b1;
          estado_n    = REGISTRA_MACRO;
        end else if (timer_hit) begin
          timeout     = 1'b1;
          jogador_n   = jogador_prox;
          timer_clear = 1'b1;
          estado_n    = ESPERA_MACRO;
        end
      end
      REGISTRA_MACRO: begin
        macro_n  = escolha;
        estado_n = ESPERA_MICRO;
      end
      ESPERA_MICRO: begin
        timer_count = 1'b1;
        if (press) begin
          micro_n     = indice;
          timer_clear = 1'b1;
          estado_n    = VALIDA_MICRO;
        end else if (timer_hit) begin
          timeout     = 1'b1;
          jogador_n   = jogador_prox;
          timer_clear = 1'b1;
          estado_n    = ESPERA_MACRO;
        end
      end
      VALIDA_MICRO: begin
        estado_n = micro_ocupada[micro] ? ESPERA_MICRO : COMMIT;
      end
      COMMIT: begin
        estado_n = TROCA;
      end
      TROCA: begin
        timer_clear = 1'b1;
        if (fim_jogo) begin
          estado_n = FIM;
        end else begin
          jogador_n = jogador_prox;
          // The cell just played names the board the next player must use,
          // unless that board is already closed.
          if (!macro_ocupada[micro]) begin
            macro_n  = micro;
            estado_n = ESPERA_MICRO;
          end else begin
            estado_n = ESPERA_MACRO;
          end
        end
      end
      FIM: begin
        if (iniciar) estado_n = PREPARA;
      end
      default: begin
        estado_n = INICIAL;
      end
    endcase
  end

  assign jogada_valida = (estado == COMMIT);
  assign jogar_macro   = (estado == ESPERA_MACRO);
  assign jogar_micro   = (estado == ESPERA_MICRO);
  assign pronto        = (estado == FIM);
  assign db_estado     = estado;

endmodule

// File: doc/controlador_rodada.md
CONTROLADOR_RODADA -- requirements
Module: controlador_rodada

Interface
REQ-001 Parameter CELLS, default 9: cells per micro board and micro boards per macro board; legal range 4..16.
REQ-002 Parameter PLAYERS, default 2: number of players; legal range 2..4.
REQ-003 Parameter TIMEOUT, default 5000: cycles allowed per turn before forfeit; legal range >= 2.
REQ-004 Derived widths: IW = clog2(CELLS), PW = max(1, clog2(PLAYERS)).
REQ-005 Port clock, input, 1: single clock; all logic on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port iniciar, input, 1: level; starts a game from INICIAL or FIM.
REQ-008 Port botoes, input, CELLS: raw cell buttons, active-high.
REQ-009 Port macro_ocupada, input, CELLS: bit i set when macro board i is won or full.
REQ-010 Port micro_ocupada, input, CELLS: occupancy of the cells of the currently selected macro board.
REQ-011 Port fim_jogo, input, 1: game-over flag from board logic.
REQ-012 Port macro, output, IW: selected macro board index.
REQ-013 Port micro, output, IW: selected micro cell index.
REQ-014 Port jogador, output, PW: current player.
REQ-015 Port jogada_valida, output, 1: one-cycle commit strobe for (macro, micro, jogador).
REQ-016 Port jogar_macro, output, 1: waiting for a macro choice.
REQ-017 Port jogar_micro, output, 1: waiting for a micro choice.
REQ-018 Port timeout, output, 1: one-cycle forfeit pulse.
REQ-019 Port pronto, output, 1: level; game over.
REQ-020 Port db_estado, output, 4: encoding of the current state.

Function
REQ-021 A press is a 0->1 transition on the synchronised botoes in which exactly one bit rises; multi-bit rises are ignored. The press is detected one cycle after sampling.
REQ-022 States and codes: INICIAL=0, PREPARA=1, ESPERA_MACRO=2, REGISTRA_MACRO=3, ESPERA_MICRO=4, VALIDA_MICRO=5, COMMIT=6, TROCA=7, FIM=8.
REQ-023 INICIAL -> PREPARA on iniciar. PREPARA clears macro, micro, jogador and the timer, and selects free choice; then -> ESPERA_MACRO.
REQ-024 ESPERA_MACRO: jogar_macro=1. A press on index k with macro_ocupada[k]=0 -> REGISTRA_MACRO. A press on an occupied board is ignored.
REQ-025 REGISTRA_MACRO latches macro=k -> ESPERA_MICRO.
REQ-026 ESPERA_MICRO: jogar_micro=1. A press on index m -> VALIDA_MICRO with micro=m.
REQ-027 VALIDA_MICRO: if micro_ocupada[m]=1 -> ESPERA_MICRO (rejected); else -> COMMIT.
REQ-028 COMMIT: jogada_valida=1 for exactly one cycle -> TROCA.
REQ-029 TROCA: if fim_jogo=1 -> FIM; else advance jogador and set the next macro.
- jogador advances modulo PLAYERS (PLAYERS-1 wraps to 0).
- Next macro is forced to m if macro_ocupada[m]=0: macro=m, -> ESPERA_MICRO.
- Otherwise free choice: -> ESPERA_MACRO.
REQ-030 FIM: pronto=1 and all selections are held; iniciar -> PREPARA.
REQ-031 Turn timer clears on entry to TROCA and PREPARA and counts in ESPERA_MACRO and ESPERA_MICRO.
REQ-032 On reaching TIMEOUT-1: timeout pulses, jogador advances, choice becomes free, -> ESPERA_MACRO. No jogada_valida is issued.
REQ-033 Timeout and a press in the same cycle: the press wins and the timer clears.
REQ-034 Press indices >= CELLS are impossible by width; unused bits are ignored.

Reset
REQ-035 reset=0 forces, asynchronously:
- state INICIAL;
- macro=0, micro=0, jogador=0;
- the timer and edge registers cleared;
- all strobes and flags 0; db_estado=0.
REQ-036 Reset asserted mid-turn discards the pending selection; no jogada_valida or timeout is emitted.

Configuration
REQ-037 Macro TURN_TIMEOUT_EN:
- Defined: REQ-031..REQ-033 apply.
- Undefined: no timer hardware; timeout is tied to 0; waits are unbounded.

Structure
REQ-038 Package jogo_pkg holds:
- the state enum and the db_estado codes;
- the clog2 helper;
- default parameter constants.
REQ-039 Sub-module detector_botao holds the synchroniser, the single-rise edge detector and the one-hot-to-index encoder, parametrised by CELLS.

Verification
REQ-040 Reset, iniciar, botoes=9'h010 then release, then 9'h001 -> macro=4, micro=0, jogada_valida pulse, jogador 0->1, forced macro=0 with jogar_micro=1.
REQ-041 macro_ocupada[3]=1 and press 3 while jogar_macro=1 -> ignored; stays in ESPERA_MACRO; db_estado=2.
REQ-042 micro_ocupada[5]=1 and press 5 -> no jogada_valida; returns to db_estado=4; press 6 -> commit micro=6.
REQ-043 TIMEOUT=20, TURN_TIMEOUT_EN defined, no press -> timeout pulses on the 20th wait cycle, jogador 0->1, jogar_macro=1.
REQ-044 PLAYERS=3: three commits -> jogador 0,1,2,0; botoes=9'h003 (two simultaneous rises) is ignored.
REQ-045 fim_jogo=1 during TROCA -> pronto=1, db_estado=8; iniciar -> jogador=0, db_estado=2; reset=0 mid-ESPERA_MICRO -> all outputs 0 immediately.
